spi_sram_responder: RTL
=======================

Name: spi_sram_responder

Overview:
- SPI target that emulates a 23LC-series serial SRAM, backed by an on-chip byte array. It is the far end of the SRAM SPI link driven by the memory controller's SPI master.
- Used as the SRAM stand-in for FPGA builds and as the responder model for full-system simulation.
- Oversampled design: SPI pins are synchronised into clk, and all logic runs on clk.

Parameters:
- ADDR_W, 10, byte-address width of the backing array (DEPTH = 2**ADDR_W bytes).
- MODE_DEFAULT, 8'h40, mode register value after reset (bits[7:6]: 00 byte, 10 page, 01 sequential, 11 treated as sequential).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- sclk  in  1  SPI clock from master, mode 0, asynchronous to clk.
- ce  in  1  chip enable from master, active-low, asynchronous.
- si  in  1  serial data from master.
- so  out  1  serial data to master.
- so_oe  out  1  high while the responder drives so (read data or mode readback).
- active  out  1  high while the synchronised ce is low.

Behaviour:
- Reset is synchronous, active-low, on clk. Reset values: so=0, so_oe=0, active=0, mode=MODE_DEFAULT, state=IDLE, bit counter=0. The array is not reset.
- sclk, ce and si each pass through a 2-flop synchroniser. Rising and falling edges of sclk are detected from the synchronised value plus one history flop.
- Pin-to-action latency is 3 clk. Requirement on the master: sclk high and low phases ≥ 4 clk each.
- si is sampled on a detected sclk rising edge, MSB first. so updates on a detected sclk falling edge.
- States: IDLE, CMD, ADDR, READ, WRITE, WRMR, RDMR, IGNORE.
- IDLE -> CMD on synchronised ce falling edge; clear the bit counter.
- CMD: shift 8 bits, then decode:
  - 0x03 -> ADDR (read).
  - 0x02 -> ADDR (write).
  - 0x01 -> WRMR.
  - 0x05 -> RDMR; load mode into the shift register.
  - anything else -> IGNORE.
- ADDR: shift 24 bits. Only addr[ADDR_W-1:0] is kept; upper bits are ignored (aliasing). After the 24th bit, go to READ or WRITE.
  - For read: within 1 clk, load mem[addr] into the tx shift register; so_oe=1.
  - The MSB appears on so at the next detected sclk falling edge.
- READ:
  - Shift one bit per falling edge.
  - After 8 bits, advance the address per mode and reload the tx register on the same falling edge, so no idle bit appears between bytes.
  - Byte mode: after the first byte, so=0 until ce rises.
- WRITE:
  - After each complete 8 bits, write the byte to mem[addr] in one clk, then advance the address per mode.
  - Byte mode: only the first byte is stored; later bytes are discarded.
- Address advance:
  - Sequential: addr+1 mod DEPTH.
  - Page: addr[4:0]+1 wraps within the 32-byte page; upper bits are unchanged.
- WRMR: after 8 bits, mode <= received byte; further bits are ignored.
- RDMR: shift out mode MSB-first with so_oe=1; after 8 bits, so=0.
- IGNORE: so_oe=0; wait for ce to rise.
- Synchronised ce rising in any state -> IDLE next clk:
  - so_oe=0, so=0.
  - A partially received byte is discarded, with no array or mode write.
- ce rising at the exact clk of a completing 8th bit: the byte commits before the abort takes effect.
- ce falling while already in a non-IDLE state cannot occur; ce must rise first.
- Reset asserted mid-transaction: return to the reset values next clk. A byte write in flight on that clk does not commit.

Test Plan:
- Write 0x02, addr 0x000010, data 0xDE 0xAD 0xBE 0xEF (sequential); then read 0x03 at 0x000010 for 4 bytes -> so returns DE AD BE EF with so_oe=1 only during the data phase.
- Sequential wrap: write 0x11, 0x22 at DEPTH-1 (0x3FF); read 1 byte at 0x000 -> 0x22.
- Page mode via WRMR 0x80, then RDMR -> 0x80. Write 0xA1, 0xA2 at 0x3F -> 0xA2 lands at 0x20, and 0x40 is unchanged.
- Byte mode (WRMR 0x00): write 3 bytes at 0x005 -> only mem[0x005] changes; a 2-byte read returns byte then 0x00.
- Abort: write command plus address 0x000030, 5 data bits, ce high -> mem[0x030] unchanged; the next transaction decodes normally.
- Unknown command 0x9F followed by 32 clocks -> so_oe stays 0 and the array is untouched. After reset, RDMR returns 0x40.

Source files
------------

// File: rtl/spi_sram_responder.sv
// 23LC-style serial SRAM emulator on an oversampled SPI mode-0 link, backed by a byte array.
// Pin-to-action latency 3 clk; no backpressure, the master paces everything (sclk phases >= 4 clk).
module spi_sram_responder #(
  parameter int         ADDR_W       = 10,
  parameter logic [7:0] MODE_DEFAULT = 8'h40
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic ce,
  input  logic si,
  output logic so,
  output logic so_oe,
  output logic active
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, WRMR, RDMR, IGNORE} state_t;

  logic sclk_meta, sclk_sync, sclk_hist;
  logic ce_meta, ce_sync, ce_hist;
  logic si_meta, si_sync;

  state_t            state, state_nxt;
  logic [4:0]        bit_cnt, bit_cnt_nxt;
  logic [6:0]        rx_sh, rx_nxt;
  logic [7:0]        tx_sh, tx_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt, addr_adv, addr_shift, rd_addr;
  logic [7:0]        mode, mode_nxt;
  logic              so_nxt, so_oe_nxt;
  logic              is_rd, is_rd_nxt;
  logic              byte_done, byte_done_nxt;
  logic              mem_we;
  logic [7:0]        rx_byte, mem_rd;
  logic              sclk_rise, sclk_fall, ce_fall, ce_rise;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_hist <= 1'b0;
      ce_meta   <= 1'b1;
      ce_sync   <= 1'b1;
      ce_hist   <= 1'b1;
      si_meta   <= 1'b0;
      si_sync   <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_hist <= sclk_sync;
      ce_meta   <= ce;
      ce_sync   <= ce_meta;
      ce_hist   <= ce_sync;
      si_meta   <= si;
      si_sync   <= si_meta;
    end
  end

  assign sclk_rise = sclk_sync & ~sclk_hist;
  assign sclk_fall = ~sclk_sync & sclk_hist;
  assign ce_fall   = ~ce_sync & ce_hist;
  assign ce_rise   = ce_sync & ~ce_hist;
  assign active    = ~ce_sync;

  assign rx_byte    = {rx_sh, si_sync};
  assign addr_shift = {addr[ADDR_W-2:0], si_sync};
  // Page mode wraps inside the 32-byte page; modes 01 and 11 are both sequential.
  assign addr_adv   = (mode[7:6] == 2'b10) ? {addr[ADDR_W-1:5], addr[4:0] + 5'd1}
                                           : addr + ADDR_W'(1);
  // The first read byte comes from the address still being shifted in.
  assign rd_addr    = (state == ADDR) ? addr_shift : addr_adv;
  assign mem_rd     = mem[rd_addr];

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_nxt        = rx_sh;
    tx_nxt        = tx_sh;
    addr_nxt      = addr;
    mode_nxt      = mode;
    so_nxt        = so;
    so_oe_nxt     = so_oe;
    is_rd_nxt     = is_rd;
    byte_done_nxt = byte_done;
    mem_we        = 1'b0;
    case (state)
      IDLE: begin
        if (ce_fall) begin
          state_nxt     = CMD;
          bit_cnt_nxt   = 5'd0;
          byte_done_nxt = 1'b0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          rx_nxt      = rx_byte[6:0];
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            bit_cnt_nxt = 5'd0;
            case (rx_byte)
              8'h03: begin state_nxt = ADDR; is_rd_nxt = 1'b1; end
              8'h02: begin state_nxt = ADDR; is_rd_nxt = 1'b0; end
              8'h01: state_nxt = WRMR;
              8'h05: begin state_nxt = RDMR; tx_nxt = mode; so_oe_nxt = 1'b1; end
              default: state_nxt = IGNORE;
            endcase
          end
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          addr_nxt    = addr_shift;
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd23) begin
            bit_cnt_nxt = 5'd0;
            if (is_rd) begin
              state_nxt = READ;
              tx_nxt    = mem_rd;
              so_oe_nxt = 1'b1;
            end else begin
              state_nxt = WRITE;
            end
          end
        end
      end
      READ: begin
        if (sclk_fall) begin
          so_nxt      = tx_sh[7];
          tx_nxt      = {tx_sh[6:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            bit_cnt_nxt = 5'd0;
            addr_nxt    = addr_adv;
            tx_nxt      = (mode[7:6] == 2'b00) ? 8'h00 : mem_rd;
          end
        end
      end
      WRITE: begin
        if (sclk_rise) begin
          rx_nxt      = rx_byte[6:0];
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            bit_cnt_nxt = 5'd0;
            mem_we      = ~byte_done;
            addr_nxt    = addr_adv;
            if (mode[7:6] == 2'b00) byte_done_nxt = 1'b1;
          end
        end
      end
      WRMR: begin
        if (sclk_rise) begin
          rx_nxt      = rx_byte[6:0];
          bit_cnt_nxt = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            bit_cnt_nxt = 5'd0;
            mode_nxt    = rx_byte;
            state_nxt   = IGNORE;
          end
        end
      end
      RDMR: begin
        if (sclk_fall) begin
          so_nxt = tx_sh[7];
          tx_nxt = {tx_sh[6:0], 1'b0};
        end
      end
      IGNORE: so_oe_nxt = 1'b0;
      default: state_nxt = IDLE;
    endcase
    // Abort overrides the state but leaves a byte completing on this clk committed.
    if (ce_rise) begin
      state_nxt   = IDLE;
      so_nxt      = 1'b0;
      so_oe_nxt   = 1'b0;
      bit_cnt_nxt = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      rx_sh     <= 7'd0;
      tx_sh     <= 8'd0;
      addr      <= '0;
      mode      <= MODE_DEFAULT;
      so        <= 1'b0;
      so_oe     <= 1'b0;
      is_rd     <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      rx_sh     <= rx_nxt;
      tx_sh     <= tx_nxt;
      addr      <= addr_nxt;
      mode      <= mode_nxt;
      so        <= so_nxt;
      so_oe     <= so_oe_nxt;
      is_rd     <= is_rd_nxt;
      byte_done <= byte_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[addr] <= rx_byte;
  end

endmodule
